// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates an 8-bit stimulus into a 12-bit
// membrane with shift-based leak, fires a spike and then holds off for a fixed refractory time.
module lif_neuron #(
   parameter int THRESHOLD     = 200,
   parameter int LEAK_SHIFT    = 3,
   parameter int REFRAC_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_current,
   output logic        spike,
   output logic [11:0] membrane,
   output logic        refractory,
   output logic [7:0]  spike_count
);

   typedef enum logic {
      INTEGRATE  = 1'b0,
      REFRACTORY = 1'b1
   } state_t;

   localparam logic [12:0] THRESH_13   = 13'(THRESHOLD);
   localparam logic [12:0] MEM_MAX_13  = 13'd4095;
   localparam logic [7:0]  REFRAC_INIT = 8'(REFRAC_CYCLES);

   state_t      state_q, state_d;
   logic        spike_q, spike_d;
   logic [11:0] membrane_q, membrane_d;
   logic        refractory_q, refractory_d;
   logic [7:0]  spike_count_q, spike_count_d;
   logic [7:0]  refrac_cnt_q, refrac_cnt_d;

   logic [11:0] leak;
   logic [12:0] stim;
   logic [12:0] sum_raw;
   logic [11:0] sum_sat;
   logic        fire;

   // Sum is formed at 13 bits so that an overflow past 4095 can be clamped.
   always_comb begin
      leak    = membrane_q >> LEAK_SHIFT;
      stim    = in_valid ? {5'd0, in_current} : 13'd0;
      sum_raw = {1'b0, membrane_q} - {1'b0, leak} + stim;
      sum_sat = (sum_raw > MEM_MAX_13) ? 12'hFFF : sum_raw[11:0];
      fire    = ({1'b0, sum_sat} >= THRESH_13);
   end

   always_comb begin
      state_d       = state_q;
      spike_d       = 1'b0;
      membrane_d    = membrane_q;
      refractory_d  = refractory_q;
      spike_count_d = spike_count_q;
      refrac_cnt_d  = refrac_cnt_q;
      unique case (state_q)
         INTEGRATE: begin
            if (fire) begin
               spike_d       = 1'b1;
               membrane_d    = 12'd0;
               spike_count_d = spike_count_q + 8'd1;
               refrac_cnt_d  = REFRAC_INIT;
               refractory_d  = 1'b1;
               state_d       = REFRACTORY;
            end else begin
               membrane_d = sum_sat;
            end
         end
         REFRACTORY: begin
            membrane_d   = 12'd0;
            refrac_cnt_d = refrac_cnt_q - 8'd1;
            // A count of 0 cannot occur here; treat it like 1 so the FSM can never stick.
            if (refrac_cnt_q <= 8'd1) begin
               refrac_cnt_d = 8'd0;
               refractory_d = 1'b0;
               state_d      = INTEGRATE;
            end
         end
         default: begin
            state_d = INTEGRATE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= INTEGRATE;
         spike_q       <= 1'b0;
         membrane_q    <= 12'd0;
         refractory_q  <= 1'b0;
         spike_count_q <= 8'd0;
         refrac_cnt_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         spike_q       <= spike_d;
         membrane_q    <= membrane_d;
         refractory_q  <= refractory_d;
         spike_count_q <= spike_count_d;
         refrac_cnt_q  <= refrac_cnt_d;
      end
   end

   assign spike       = spike_q;
   assign membrane    = membrane_q;
   assign refractory  = refractory_q;
   assign spike_count = spike_count_q;

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 THRESHOLD, default 200, firing threshold on membrane potential; legal range 1..4095.
REQ-002 LEAK_SHIFT, default 3, leak per cycle is membrane >> LEAK_SHIFT; legal range 1..11.
REQ-003 REFRAC_CYCLES, default 4, refractory length in clock cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-006 in_valid  input  1  in_current is sampled on this edge when high.
REQ-007 in_current  input  8  unsigned stimulus, produced by the upstream 8-bit counter `value` output.
REQ-008 spike  output  1  one-cycle pulse on firing.
REQ-009 membrane  output  12  unsigned membrane potential register.
REQ-010 refractory  output  1  high while in REFRACTORY state.
REQ-011 spike_count  output  8  running count of spikes.

Function
REQ-012 States: INTEGRATE and REFRACTORY; reset state INTEGRATE.
REQ-013 All outputs are registered, with no combinational path from inputs to outputs.
REQ-014 INTEGRATE, per edge: sum = membrane - (membrane >> LEAK_SHIFT) + (in_valid ? in_current : 0), computed at ≥13 bits and saturated to 4095.
REQ-015 INTEGRATE, sum < THRESHOLD: membrane <= sum, spike <= 0.
REQ-016 INTEGRATE, sum >= THRESHOLD (after saturation):
- spike <= 1 and membrane <= 0;
- spike_count <= spike_count + 1;
- refrac counter <= REFRAC_CYCLES;
- next state REFRACTORY, refractory <= 1.
REQ-017 Latency: a crossing input sampled at edge N gives spike=1 after edge N; spike is never high for two consecutive cycles.
REQ-018 REFRACTORY, per edge:
- in_valid and in_current are ignored;
- membrane held at 0, spike <= 0;
- refrac counter decrements;
- when the counter was 1, next state is INTEGRATE and refractory <= 0.
REQ-019 Consequence of REQ-016/REQ-018: refractory is high for exactly REFRAC_CYCLES cycles starting with the spike cycle; the first integrating edge is edge N+REFRAC_CYCLES+1.
REQ-020 Leak floors: membrane < 2^LEAK_SHIFT with no input holds its value and never decays to 0.
REQ-021 spike_count wraps 255 -> 0 with no flag.
REQ-022 in_valid=0 in INTEGRATE applies leak only.
REQ-023 A membrane value at the 4095 cap always fires, since THRESHOLD <= 4095.

Reset
REQ-024 On reset=0 the following take effect asynchronously:
- spike=0, membrane=0, refractory=0, spike_count=0;
- refrac counter=0, state=INTEGRATE.
REQ-025 Reset asserted mid-REFRACTORY or mid-integration discards all state; there is no carry-over after release.
REQ-026 The first edge with reset=1 performs a normal INTEGRATE update.

Verification (defaults: THRESHOLD=200, LEAK_SHIFT=3, REFRAC_CYCLES=4)
REQ-027 Constant in_current=100, in_valid=1 from reset release:
- membrane reads 100, then 188;
- third edge gives spike=1, membrane=0, refractory=1, spike_count=1.
REQ-028 Refractory, input held at 100 after the REQ-027 spike:
- refractory=1 and membrane=0 for 4 cycles;
- next edge gives refractory=0 with membrane still 0;
- following edge gives membrane=100;
- second spike exactly 7 edges after the first.
REQ-029 Leak-only, membrane=188 then in_valid=0: sequence 165, 145, 127, 112, 98, ... settles at 7 and holds; spike stays 0.
REQ-030 Sub-threshold in_current=20 constant for 200 cycles: spike never asserts; membrane settles within 160..167.
REQ-031 in_current=255 constant: spike every 5 cycles; after 256 spikes spike_count=0 (wrap).
REQ-032 Reset mid-operation:
- reset=0 asynchronously between edges during REFRACTORY: all outputs read 0 before the next edge;
- after release with in_current=100: spike exactly on the third edge.
